// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, falling-edge start detection,
// mid-bit sampling, one-cycle valid / frame_err strobes.
module uart_rx #(
  parameter int SYSTEM_CLOCK = 32000000,
  parameter int BAUD_RATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] state_out_dbg
);

  localparam int CLKS_PER_BIT = SYSTEM_CLOCK / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_sync1;
  logic            r_rxd_s;
  logic            r_rxd_q;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;

  logic            w_fall;
  logic            w_half_hit;
  logic            w_full_hit;
  logic            w_cnt_clr;
  logic            w_idx_clr;
  logic            w_shift_en;
  logic            w_good;
  logic            w_bad;

  assign w_fall     = r_rxd_q & ~r_rxd_s;
  assign w_half_hit = (r_cnt == CNT_HALF);
  assign w_full_hit = (r_cnt == CNT_FULL);

  // Synchronizer and edge-detect flops; reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_q <= 1'b1;
    end else begin
      r_sync1 <= din;
      r_rxd_s <= r_sync1;
      r_rxd_q <= r_rxd_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a line held low in IDLE never retriggers (edge only).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_fall) w_next_state = START;
        else        w_next_state = IDLE;
      end
      START: begin
        if (w_half_hit) w_next_state = r_rxd_s ? IDLE : DATA;
        else            w_next_state = START;
      end
      DATA: begin
        if (w_full_hit && (r_idx == 3'd7)) w_next_state = STOP;
        else                               w_next_state = DATA;
      end
      STOP: begin
        if (w_full_hit) w_next_state = IDLE;
        else            w_next_state = STOP;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_idx_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
      end
      START: begin
        w_cnt_clr = w_half_hit;
        w_idx_clr = w_half_hit;
      end
      DATA: begin
        w_cnt_clr  = w_full_hit;
        w_shift_en = w_full_hit;
      end
      STOP: begin
        w_cnt_clr = w_full_hit;
        w_good    = w_full_hit & r_rxd_s;
        w_bad     = w_full_hit & ~r_rxd_s;
      end
      default: begin
        w_cnt_clr = 1'b1;
      end
    endcase
  end

  // Bit-timing counter, bit index and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : (r_cnt + CW'(1));
      if (w_idx_clr) begin
        r_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + 3'd1;
      end else begin
        r_idx <= r_idx;
      end
      if (w_shift_en) begin
        r_shift[r_idx] <= r_rxd_s;
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  // Registered result strobes; data_out only moves on a good stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_good;
      r_ferr  <= w_bad;
      if (w_good) r_data <= r_shift;
      else        r_data <= r_data;
    end
  end

  assign data_out      = r_data;
  assign valid         = r_valid;
  assign frame_err     = r_ferr;
  assign busy          = (r_state != IDLE);
  assign state_out_dbg = r_state;

endmodule
